fc_xcvr_link_ctrl: RTL and testbench

Bring-up and supervision sequencer for the 8G Fibre Channel transceiver PHY.
- Holds the PHY in reset, then releases it.
- Waits for TX ready, then RX ready, then word alignment on all four byte lanes (rx_syncstatus).
- Declares link-up and keeps monitoring the link.
- On a timeout or a debounced loss of sync, backs off and retrains.
- Sits between the management-domain reset and the PHY's reset input; exposes link status and counters to CSR logic.

---
 rtl/fc_xcvr_pkg.sv | 16 +
 rtl/fc_xcvr_sync2.sv | 27 ++
 rtl/fc_xcvr_link_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_fc_xcvr_link_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_xcvr_pkg.sv
// Shared types and constants for the Fibre Channel transceiver link sequencer.
package fc_xcvr_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    WAIT_TX   = 3'd2,
    WAIT_RX   = 3'd3,
    WAIT_SYNC = 3'd4,
    LINK_UP   = 3'd5,
    BACKOFF   = 3'd6
  } state_t;

  localparam int RETRAIN_CNT_W = 16;

endpackage

// File: rtl/fc_xcvr_sync2.sv
// Two-flop synchronizer for a bundle of quasi-static status bits from the PHY domain.
module fc_xcvr_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture; only the second stage is consumed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/fc_xcvr_link_ctrl.sv
// PHY bring-up / supervision sequencer: reset hold, TX/RX ready, lane sync,
// link monitoring with debounced sync loss, and timed backoff before retrain.
module fc_xcvr_link_ctrl
  import fc_xcvr_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES  = 64,
  parameter int TX_READY_TIMEOUT   = 100000,
  parameter int RX_READY_TIMEOUT   = 100000,
  parameter int SYNC_TIMEOUT       = 50000,
  parameter int SYNC_LOSS_DEBOUNCE = 16,
  parameter int BACKOFF_CYCLES     = 1000,
  parameter int LANES              = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     phy_tx_ready,
  input  logic                     phy_rx_ready,
  input  logic [LANES-1:0]         phy_rx_syncstatus,
  output logic                     phy_reset,
  output logic                     link_up,
  output logic [2:0]               state,
  output logic [RETRAIN_CNT_W-1:0] retrain_count,
  output logic                     timeout_err,
  input  logic                     clear_stats
);

  localparam int T_MAX_A = (RESET_HOLD_CYCLES > TX_READY_TIMEOUT) ? RESET_HOLD_CYCLES : TX_READY_TIMEOUT;
  localparam int T_MAX_B = (RX_READY_TIMEOUT > SYNC_TIMEOUT) ? RX_READY_TIMEOUT : SYNC_TIMEOUT;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > BACKOFF_CYCLES) ? T_MAX_C : BACKOFF_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX) + 1;
  localparam int LOSS_W  = $clog2(SYNC_LOSS_DEBOUNCE + 1);

  localparam logic [TIMER_W-1:0] HOLD_LOAD    = TIMER_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TX_LOAD      = TIMER_W'(TX_READY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RX_LOAD      = TIMER_W'(RX_READY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SYNC_LOAD    = TIMER_W'(SYNC_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BACKOFF_LOAD = TIMER_W'(BACKOFF_CYCLES - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST    = LOSS_W'(SYNC_LOSS_DEBOUNCE - 1);
  localparam logic [RETRAIN_CNT_W-1:0] RETRAIN_MAX = {RETRAIN_CNT_W{1'b1}};

  logic [LANES+1:0] sync_in_s;
  logic [LANES+1:0] sync_out_s;
  logic             tx_ready_s;
  logic             rx_ready_s;
  logic             sync_all_s;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [TIMER_W-1:0]       timer_r;
  logic [TIMER_W-1:0]       timer_nxt_s;
  logic [LOSS_W-1:0]        loss_r;
  logic [LOSS_W-1:0]        loss_nxt_s;
  logic                     expired_s;
  logic                     timeout_s;
  logic                     backoff_entry_s;
  logic                     phy_reset_r;
  logic                     link_up_r;
  logic [RETRAIN_CNT_W-1:0] retrain_cnt_r;
  logic [RETRAIN_CNT_W-1:0] retrain_nxt_s;
  logic                     timeout_err_r;
  logic                     timeout_err_nxt_s;

  assign sync_in_s = {phy_tx_ready, phy_rx_ready, phy_rx_syncstatus};

  fc_xcvr_sync2 #(.WIDTH(LANES + 2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sync_in_s),
    .q     (sync_out_s)
  );

  assign tx_ready_s = sync_out_s[LANES+1];
  assign rx_ready_s = sync_out_s[LANES];
  assign sync_all_s = &sync_out_s[LANES-1:0];
  assign expired_s  = (timer_r == {TIMER_W{1'b0}});

  // Next-state selection: enable drop beats success, success beats expiry.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    if (!enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = HOLD;
        HOLD: begin
          if (expired_s) state_nxt_s = WAIT_TX;
          else           state_nxt_s = HOLD;
        end
        WAIT_TX: begin
          if (tx_ready_s) begin
            state_nxt_s = WAIT_RX;
          end else if (expired_s) begin
            state_nxt_s = BACKOFF;
            timeout_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT_TX;
          end
        end
        WAIT_RX: begin
          if (rx_ready_s) begin
            state_nxt_s = WAIT_SYNC;
          end else if (!tx_ready_s) begin
            state_nxt_s = BACKOFF;
          end else if (expired_s) begin
            state_nxt_s = BACKOFF;
            timeout_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT_RX;
          end
        end
        WAIT_SYNC: begin
          if (sync_all_s) begin
            state_nxt_s = LINK_UP;
          end else if (expired_s) begin
            state_nxt_s = BACKOFF;
            timeout_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT_SYNC;
          end
        end
        LINK_UP: begin
          if (!tx_ready_s || !rx_ready_s) begin
            state_nxt_s = BACKOFF;
          end else if (!sync_all_s && (loss_r == LOSS_LAST)) begin
            state_nxt_s = BACKOFF;
          end else begin
            state_nxt_s = LINK_UP;
          end
        end
        BACKOFF: begin
          if (expired_s) state_nxt_s = HOLD;
          else           state_nxt_s = BACKOFF;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Timer reload on state entry, loss run length, and statistics update.
  always_comb begin
    timer_nxt_s       = timer_r;
    loss_nxt_s        = {LOSS_W{1'b0}};
    retrain_nxt_s     = retrain_cnt_r;
    timeout_err_nxt_s = timeout_err_r;
    backoff_entry_s   = (state_nxt_s == BACKOFF) && (state_r != BACKOFF);

    if (state_nxt_s != state_r) begin
      case (state_nxt_s)
        HOLD:      timer_nxt_s = HOLD_LOAD;
        WAIT_TX:   timer_nxt_s = TX_LOAD;
        WAIT_RX:   timer_nxt_s = RX_LOAD;
        WAIT_SYNC: timer_nxt_s = SYNC_LOAD;
        BACKOFF:   timer_nxt_s = BACKOFF_LOAD;
        default:   timer_nxt_s = {TIMER_W{1'b0}};
      endcase
    end else if (!expired_s) begin
      timer_nxt_s = timer_r - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      timer_nxt_s = timer_r;
    end

    // Run length only survives while the link stays up.
    if ((state_r == LINK_UP) && (state_nxt_s == LINK_UP) && !sync_all_s) begin
      loss_nxt_s = loss_r + {{(LOSS_W-1){1'b0}}, 1'b1};
    end else begin
      loss_nxt_s = {LOSS_W{1'b0}};
    end

    if (clear_stats) begin
      retrain_nxt_s     = {RETRAIN_CNT_W{1'b0}};
      timeout_err_nxt_s = 1'b0;
    end else begin
      if (backoff_entry_s && (retrain_cnt_r != RETRAIN_MAX)) begin
        retrain_nxt_s = retrain_cnt_r + {{(RETRAIN_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retrain_nxt_s = retrain_cnt_r;
      end
      if (timeout_s) timeout_err_nxt_s = 1'b1;
      else           timeout_err_nxt_s = timeout_err_r;
    end
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      timer_r       <= {TIMER_W{1'b0}};
      loss_r        <= {LOSS_W{1'b0}};
      phy_reset_r   <= 1'b1;
      link_up_r     <= 1'b0;
      retrain_cnt_r <= {RETRAIN_CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      loss_r        <= loss_nxt_s;
      phy_reset_r   <= (state_nxt_s == IDLE) || (state_nxt_s == HOLD) || (state_nxt_s == BACKOFF);
      link_up_r     <= (state_r == LINK_UP) && (state_nxt_s == LINK_UP);
      retrain_cnt_r <= retrain_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign state         = state_r;
  assign phy_reset     = phy_reset_r;
  assign link_up       = link_up_r;
  assign retrain_count = retrain_cnt_r;
  assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_fc_xcvr_link_ctrl.sv
// Scoreboard bench: expected output events are queued ahead of stimulus and a
// negedge monitor pops one on every change of the observable output tuple.
module tb_fc_xcvr_link_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        phy_tx_ready;
  logic        phy_rx_ready;
  logic [3:0]  phy_rx_syncstatus;
  logic        phy_reset;
  logic        link_up;
  logic [2:0]  state;
  logic [15:0] retrain_count;
  logic        timeout_err;
  logic        clear_stats;

  always #5 clk = ~clk;

  fc_xcvr_link_ctrl #(
    .RESET_HOLD_CYCLES  (4),
    .TX_READY_TIMEOUT   (20),
    .RX_READY_TIMEOUT   (20),
    .SYNC_TIMEOUT       (20),
    .SYNC_LOSS_DEBOUNCE (3),
    .BACKOFF_CYCLES     (5),
    .LANES              (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .phy_tx_ready      (phy_tx_ready),
    .phy_rx_ready      (phy_rx_ready),
    .phy_rx_syncstatus (phy_rx_syncstatus),
    .phy_reset         (phy_reset),
    .link_up           (link_up),
    .state             (state),
    .retrain_count     (retrain_count),
    .timeout_err       (timeout_err),
    .clear_stats       (clear_stats)
  );

  typedef struct {
    logic [2:0]  st;
    logic        lu;
    logic        pr;
    logic [15:0] rc;
    logic        te;
    int          dwell;  // cycles the previous tuple was held; -1 = unchecked
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_on   = 1'b0;

  task automatic ev(input logic [2:0] st, input logic lu, input logic pr,
                    input logic [15:0] rc, input logic te, input int dwell);
    ev_t e;
    e.st = st; e.lu = lu; e.pr = pr; e.rc = rc; e.te = te; e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one scoreboard pop per observed output change.
  initial begin : monitor
    logic [21:0] cur;
    logic [21:0] last;
    logic [21:0] want;
    int          run;
    int          idx;
    bit          first;
    ev_t         e;
    first = 1'b1;
    run   = 0;
    idx   = 0;
    last  = 22'd0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur = {state, link_up, phy_reset, retrain_count, timeout_err};
        if (first || (cur != last)) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event #%0d: got state=%0d link_up=%0b phy_reset=%0b retrain=%h terr=%0b, none expected",
                     idx, state, link_up, phy_reset, retrain_count, timeout_err);
          end else begin
            e    = exp_q.pop_front();
            want = {e.st, e.lu, e.pr, e.rc, e.te};
            if (cur != want) begin
              n_fail++;
              $display("FAIL event_tuple #%0d: got state=%0d link_up=%0b phy_reset=%0b retrain=%h terr=%0b, expected state=%0d link_up=%0b phy_reset=%0b retrain=%h terr=%0b",
                       idx, state, link_up, phy_reset, retrain_count, timeout_err,
                       e.st, e.lu, e.pr, e.rc, e.te);
            end
            if (!first && (e.dwell >= 0)) begin
              n_checks++;
              if (run != e.dwell) begin
                n_fail++;
                $display("FAIL event_dwell #%0d: previous output held %0d cycles, expected %0d", idx, run, e.dwell);
              end
            end
          end
          idx++;
          first = 1'b0;
          run   = 1;
          last  = cur;
        end else begin
          run++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear_stats = 1'b0;
    phy_tx_ready = 1'b0; phy_rx_ready = 1'b0; phy_rx_syncstatus = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values, then happy path bring-up.
    ev(3'd0, 1'b0, 1'b1, 16'h0000, 1'b0, -1);
    ev(3'd1, 1'b0, 1'b1, 16'h0000, 1'b0, 1);
    ev(3'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 4);
    ev(3'd3, 1'b0, 1'b0, 16'h0000, 1'b0, 8);
    ev(3'd4, 1'b0, 1'b0, 16'h0000, 1'b0, 5);
    ev(3'd5, 1'b0, 1'b0, 16'h0000, 1'b0, 5);
    ev(3'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 1);
    mon_on = 1'b1;
    enable = 1'b1;
    cyc(10); phy_tx_ready = 1'b1;
    cyc(5);  phy_rx_ready = 1'b1;
    cyc(5);  phy_rx_syncstatus = 4'hF;

    // Two-cycle glitch is absorbed; a sustained loss retrains after three.
    ev(3'd6, 1'b0, 1'b1, 16'h0001, 1'b0, 18);
    ev(3'd1, 1'b0, 1'b1, 16'h0001, 1'b0, 5);
    ev(3'd2, 1'b0, 1'b0, 16'h0001, 1'b0, 4);
    ev(3'd3, 1'b0, 1'b0, 16'h0001, 1'b0, 1);
    ev(3'd4, 1'b0, 1'b0, 16'h0001, 1'b0, 1);
    cyc(5);  phy_rx_syncstatus = 4'hE;
    cyc(2);  phy_rx_syncstatus = 4'hF;
    cyc(10); phy_rx_syncstatus = 4'h0;

    // Enable drop while waiting for sync.
    ev(3'd0, 1'b0, 1'b1, 16'h0001, 1'b0, 4);
    cyc(19); enable = 1'b0;

    // TX ready timeout, twice; second BACKOFF entry coincides with clear_stats.
    ev(3'd1, 1'b0, 1'b1, 16'h0001, 1'b0, 8);
    ev(3'd2, 1'b0, 1'b0, 16'h0001, 1'b0, 4);
    ev(3'd6, 1'b0, 1'b1, 16'h0002, 1'b1, 20);
    ev(3'd1, 1'b0, 1'b1, 16'h0002, 1'b1, 5);
    ev(3'd2, 1'b0, 1'b0, 16'h0002, 1'b1, 4);
    ev(3'd6, 1'b0, 1'b1, 16'h0000, 1'b0, 20);
    ev(3'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1);
    cyc(4);  phy_tx_ready = 1'b0; phy_rx_ready = 1'b0;
    cyc(4);  enable = 1'b1;
    cyc(53); clear_stats = 1'b1;
    cyc(1);  clear_stats = 1'b0; enable = 1'b0;

    // Saturation from a preloaded count, then relink and reset mid-link.
    ev(3'd0, 1'b0, 1'b1, 16'hFFFE, 1'b0, -1);
    ev(3'd1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 3);
    ev(3'd2, 1'b0, 1'b0, 16'hFFFE, 1'b0, 4);
    ev(3'd6, 1'b0, 1'b1, 16'hFFFF, 1'b1, 20);
    ev(3'd1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 5);
    ev(3'd2, 1'b0, 1'b0, 16'hFFFF, 1'b1, 4);
    ev(3'd6, 1'b0, 1'b1, 16'hFFFF, 1'b1, 20);
    ev(3'd1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 5);
    ev(3'd2, 1'b0, 1'b0, 16'hFFFF, 1'b1, 4);
    ev(3'd3, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1);
    ev(3'd4, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1);
    ev(3'd5, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1);
    ev(3'd5, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1);
    ev(3'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 4);
    cyc(3);  force dut.retrain_cnt_r = 16'hFFFE;
    cyc(2);  release dut.retrain_cnt_r; enable = 1'b1;
    cyc(55); phy_tx_ready = 1'b1; phy_rx_ready = 1'b1; phy_rx_syncstatus = 4'hF;
    cyc(15); reset = 1'b1;
    cyc(1);  reset = 1'b0; enable = 1'b0;
    cyc(4);
    mon_on = 1'b0;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: %0d expected events never observed, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
